// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data, fill level
// and sticky overflow/underflow flags for catching requester protocol misuse.
module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int DW    = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [DW-1:0] wr_data_i,
   output logic          full_o,
   input  logic          rd_en_i,
   output logic [DW-1:0] rd_data_o,
   output logic          empty_o,
   output logic [AW:0]   count_o,
   output logic          overflow_o,
   output logic          underflow_o
);

   logic [DW-1:0] mem_q [DEPTH];

   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic          full, empty;
   logic          wr_acc, rd_acc;

   // Flags depend only on registered pointers; the wrap bit separates full from empty.
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign wr_acc = wr_en_i && !full;
   assign rd_acc = rd_en_i && !empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_data_d   = rd_data_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
         rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
      end
      if (wr_en_i && full) begin
         overflow_d = 1'b1;
      end
      if (rd_en_i && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_data_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_data_q   <= rd_data_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is never cleared; reset only discards it by rewinding the pointers.
   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_acc) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   assign full_o      = full;
   assign empty_o     = empty;
   assign count_o     = wr_ptr_q - rd_ptr_q;
   assign rd_data_o   = rd_data_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a reference queue holds accepted words and a fill-level
// model predicts flags; each scenario task compares DUT outputs inline.
module tb_sync_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 32;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data;
   logic          full, empty, ovf, unf;
   logic [AW:0]   count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] sb [$];
   int            m_count = 0;
   logic [DW-1:0] m_rd    = '0;
   logic          m_ovf   = 1'b0;
   logic          m_unf   = 1'b0;

   sync_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .full_o     (full),
      .rd_en_i    (rd_en),
      .rd_data_o  (rd_data),
      .empty_o    (empty),
      .count_o    (count),
      .overflow_o (ovf),
      .underflow_o(unf)
   );

   always #5 clk = ~clk;

   // One clock with the given requests; updates the reference model and
   // returns 1ns after the rising edge with inputs released.
   task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                       output logic racc);
      logic wacc;
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      wacc = we && (m_count != DEPTH);
      racc = re && (m_count != 0);
      if (we && m_count == DEPTH) m_ovf = 1'b1;
      if (re && m_count == 0)     m_unf = 1'b1;
      if (racc) m_rd = sb.pop_front();
      if (wacc) sb.push_back(wd);
      m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      sb.delete();
      m_count = 0;
      m_rd    = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic test_reset();
      logic r;
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 32'h7000 + i, 1'b0, r);
      step(1'b0, '0, 1'b1, r);
      do_reset();
      n_checks++;
      if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || rd_data !== 32'd0 ||
          ovf !== 1'b0 || unf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: empty=%b full=%b count=%0d rd=%h ovf=%b unf=%b, required 1 0 0 0 0 0",
                  empty, full, count, rd_data, ovf, unf);
      end
   endtask

   task automatic test_fill_drain();
      logic r;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 32'h1000 + i, 1'b0, r);
         n_checks++;
         if (count !== 5'(i + 1) || empty !== 1'b0 || full !== (i == DEPTH - 1) || rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL fill[%0d]: count=%0d full=%b empty=%b rd=%h, required count=%0d",
                     i, count, full, empty, rd_data, i + 1);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, '0, 1'b1, r);
         n_checks++;
         if (rd_data !== 32'h1000 + i || count !== 5'(DEPTH - 1 - i) || full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain[%0d]: rd=%h count=%0d full=%b, required rd=%h count=%0d",
                     i, rd_data, count, full, 32'h1000 + i, DEPTH - 1 - i);
         end
      end
      n_checks++;
      if (empty !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_end: empty=%b ovf=%b unf=%b, required 1 0 0", empty, ovf, unf);
      end
   endtask

   task automatic test_overflow();
      logic r;
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h4000 + i, 1'b0, r);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'hDEAD, 1'b0, r);
         n_checks++;
         if (ovf !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_hold[%0d]: ovf=%b count=%0d full=%b, required 1 16 1", i, ovf, count, full);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, '0, 1'b1, r);
         n_checks++;
         if (rd_data !== 32'h4000 + i || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drain[%0d]: rd=%h ovf=%b, required rd=%h ovf=1", i, rd_data, ovf, 32'h4000 + i);
         end
      end
      step(1'b0, '0, 1'b1, r);
      n_checks++;
      if (rd_data !== 32'h400F || unf !== 1'b1 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow_hold: rd=%h unf=%b empty=%b, required rd=0000400f unf=1 empty=1", rd_data, unf, empty);
      end
   endtask

   task automatic test_simul_full();
      logic r;
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h3000 + i, 1'b0, r);
      step(1'b1, 32'hBEEF, 1'b1, r);
      n_checks++;
      if (count !== 5'd15 || ovf !== 1'b1 || full !== 1'b0 || rd_data !== 32'h3000) begin
         n_fail++;
         $display("FAIL simul_full: count=%0d ovf=%b full=%b rd=%h, required 15 1 0 00003000",
                  count, ovf, full, rd_data);
      end
      for (int i = 1; i < DEPTH; i++) begin
         step(1'b0, '0, 1'b1, r);
         n_checks++;
         if (rd_data !== 32'h3000 + i) begin
            n_fail++;
            $display("FAIL simul_full_drain[%0d]: rd=%h, required %h", i, rd_data, 32'h3000 + i);
         end
      end
      n_checks++;
      if (empty !== 1'b1 || unf !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_full_end: empty=%b unf=%b, required 1 0", empty, unf);
      end
   endtask

   task automatic test_simul_empty();
      logic r;
      do_reset();
      step(1'b1, 32'hCAFE, 1'b1, r);
      n_checks++;
      if (count !== 5'd1 || unf !== 1'b1 || empty !== 1'b0 || rd_data !== 32'd0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_empty: count=%0d unf=%b empty=%b rd=%h ovf=%b, required 1 1 0 0 0",
                  count, unf, empty, rd_data, ovf);
      end
      step(1'b0, '0, 1'b1, r);
      n_checks++;
      if (rd_data !== 32'hCAFE || empty !== 1'b1 || count !== 5'd0) begin
         n_fail++;
         $display("FAIL simul_empty_read: rd=%h empty=%b count=%0d, required 0000cafe 1 0", rd_data, empty, count);
      end
   endtask

   task automatic test_wrap();
      logic r;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 32'h2000 + i, 1'b0, r);
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 32'h2003 + i, 1'b1, r);
         n_checks++;
         if (rd_data !== 32'h2000 + i || count !== 5'd3 || full !== 1'b0 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap[%0d]: rd=%h count=%0d full=%b empty=%b, required rd=%h count=3",
                     i, rd_data, count, full, empty, 32'h2000 + i);
         end
      end
      n_checks++;
      if (ovf !== 1'b0 || unf !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_flags: ovf=%b unf=%b, required 0 0", ovf, unf);
      end
   endtask

   task automatic test_random();
      logic r, we, re;
      int written = 0;
      int cycles  = 0;
      int wrate   = 100;
      int rrate   = 100;
      do_reset();
      while ((written < 1000 || m_count != 0) && cycles < 20000) begin
         if (cycles % 100 == 0) begin
            wrate = $urandom_range(30, 100);
            rrate = $urandom_range(30, 100);
         end
         we = (written < 1000) && !full && ($urandom_range(1, 100) <= wrate);
         re = !empty && ($urandom_range(1, 100) <= rrate);
         step(we, $urandom, re, r);
         if (we) written++;
         cycles++;
         n_checks++;
         if (rd_data !== m_rd || count !== 5'(m_count) || full !== (m_count == DEPTH) ||
             empty !== (m_count == 0)) begin
            n_fail++;
            $display("FAIL random[%0d]: rd=%h count=%0d full=%b empty=%b, required rd=%h count=%0d",
                     cycles, rd_data, count, full, empty, m_rd, m_count);
         end
      end
      n_checks++;
      if (cycles >= 20000) begin
         n_fail++;
         $display("FAIL random_timeout: written=%0d level=%0d, required 1000 written and drained", written, m_count);
      end
      n_checks++;
      if (ovf !== 1'b0 || unf !== 1'b0) begin
         n_fail++;
         $display("FAIL random_sticky: ovf=%b unf=%b, required 0 0", ovf, unf);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_simul_full();
      test_simul_empty();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
